speed_meas_scheduler: RTL

Time-multiplexes one shared edge-counting datapath across the robot car's wheel-encoder inputs. Runs fixed-length gate windows, one channel after another in round-robin order, and hands each channel's pulse count to the SpeedSensor AXI4-Lite register file over a valid/ready result port. Sits between the encoder pins and the register bank, and is configured from that bank's control and window registers.

---
 rtl/speed_meas_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/speed_meas_scheduler.sv
// speed_meas_scheduler: round-robin gate-window pulse counter shared across wheel-encoder channels
// Ports: s00_axi_aclk clock; s00_axi_aresetn sync active-low reset; enable/window_len configuration;
//   enc_in raw asynchronous encoder pulses; res_valid/res_ready/res_ch/res_count result handshake;
//   busy high outside IDLE; ovf_sticky per-channel saturation flags, cleared by clear_ovf.
// Option: SPEED_SCHED_TIMESTAMP_EN adds res_tstamp, the free-running cycle count latched at window end.
module speed_meas_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16,
  parameter int WIN_W = 24,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  input  logic              enable,
  input  logic [WIN_W-1:0]  window_len,
  input  logic [NUM_CH-1:0] enc_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [CNT_W-1:0]  res_count,
  output logic              busy,
  output logic [NUM_CH-1:0] ovf_sticky,
`ifdef SPEED_SCHED_TIMESTAMP_EN
  output logic [31:0]       res_tstamp,
`endif
  input  logic              clear_ovf
);
  typedef enum logic [1:0] {IDLE, ARM, COUNT, POST} state_t;
  state_t r_state, w_next;
  logic [NUM_CH-1:0] r_s1, r_s2, r_prev, r_ovf, w_rise, w_set;
  logic [CH_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIN_W-1:0] r_win;
  logic r_valid, w_edge, w_sat, w_xfer;
  // All channels are conditioned continuously, so moving the pointer never exposes a stale prev sample
  assign w_rise = r_s2 & ~r_prev;
  assign w_edge = w_rise[r_ptr];
  assign w_sat = &r_cnt;
  assign w_xfer = r_valid && res_ready;
  assign w_set = (r_state == COUNT && w_edge && w_sat) ? NUM_CH'(1) << r_ptr : '0;
  assign res_valid = r_valid;
  assign res_ch = r_ptr;
  assign res_count = r_cnt;
  assign busy = r_state != IDLE;
  assign ovf_sticky = r_ovf;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = enable ? ARM : IDLE;
      ARM:     w_next = enable ? COUNT : IDLE;
      COUNT:   w_next = !enable ? IDLE : (r_win == WIN_W'(1) ? POST : COUNT);
      POST:    w_next = !w_xfer ? POST : (enable ? ARM : IDLE);
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_state <= IDLE;
      r_s1 <= '0;
      r_s2 <= '0;
      r_prev <= '0;
      r_valid <= 1'b0;
      r_ptr <= '0;
      r_cnt <= '0;
      r_win <= '0;
      r_ovf <= '0;
    end else begin
      r_s1 <= enc_in;
      r_s2 <= r_s1;
      r_prev <= r_s2;
      r_state <= w_next;
      // Registered so res_ready never reaches res_valid combinationally
      r_valid <= w_next == POST;
      if (r_state == ARM) begin
        r_cnt <= '0;
        r_win <= window_len == '0 ? WIN_W'(1) : window_len;
      end
      if (r_state == COUNT) begin
        r_win <= r_win - 1'b1;
        if (w_edge && !w_sat) r_cnt <= r_cnt + 1'b1;
      end
      if (w_xfer) r_ptr <= r_ptr == CH_W'(NUM_CH - 1) ? '0 : r_ptr + 1'b1;
      // A saturation in the same cycle as clear_ovf keeps the flag set
      r_ovf <= (r_ovf & ~{NUM_CH{clear_ovf}}) | w_set;
    end
  end
`ifdef SPEED_SCHED_TIMESTAMP_EN
  logic [31:0] r_cyc, r_ts;
  assign res_tstamp = r_ts;
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_cyc <= '0;
      r_ts <= '0;
    end else begin
      r_cyc <= r_cyc + 1'b1;
      if (r_state == COUNT && w_next == POST) r_ts <= r_cyc;
    end
  end
`endif
endmodule
